// File: rtl/comb_gates_hadd.sv
// rtl/comb_gates_hadd.sv - single-bit half adder with combinational and registered outputs
module comb_gates_hadd (
   input  logic clk,
   input  logic reset,
   input  logic a,
   input  logic b,
   output logic sum,
   output logic cout,
   output logic sum_q,
   output logic cout_q
);

   logic sum_d;
   logic cout_d;

   // Combinational outputs ignore reset and always track a/b.
   assign sum  = a ^ b;
   assign cout = a & b;

   always_comb begin
      sum_d  = sum;
      cout_d = cout;
      if (reset) begin
         sum_d  = 1'b0;
         cout_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      sum_q  <= sum_d;
      cout_q <= cout_d;
   end

endmodule

// File: tb/tb_comb_gates_hadd.sv
// tb/tb_comb_gates_hadd.sv - directed self-checking bench for comb_gates_hadd
module tb_comb_gates_hadd;

   logic clk;
   logic reset;
   logic a;
   logic b;
   logic sum;
   logic cout;
   logic sum_q;
   logic cout_q;

   int pass_cnt;
   int total_cnt;

   comb_gates_hadd dut (
      .clk    (clk),
      .reset  (reset),
      .a      (a),
      .b      (b),
      .sum    (sum),
      .cout   (cout),
      .sum_q  (sum_q),
      .cout_q (cout_q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Truth-table vectors: {a, b, expected cout, expected sum}
   logic [3:0] vec [4];
   initial begin
      vec[0] = 4'b00_00;
      vec[1] = 4'b01_01;
      vec[2] = 4'b10_01;
      vec[3] = 4'b11_10;
   end

   task automatic test_reset();
      reset = 1'b1;
      a     = 1'b1;
      b     = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk);
         #1;
         total_cnt++;
         if (sum_q !== 1'b0) $display("FAIL reset_sum_q cycle %0d: got %b want 0", i, sum_q);
         else pass_cnt++;
         total_cnt++;
         if (cout_q !== 1'b0) $display("FAIL reset_cout_q cycle %0d: got %b want 0", i, cout_q);
         else pass_cnt++;
         total_cnt++;
         if (sum !== 1'b0) $display("FAIL reset_sum cycle %0d: got %b want 0", i, sum);
         else pass_cnt++;
         total_cnt++;
         if (cout !== 1'b1) $display("FAIL reset_cout cycle %0d: got %b want 1", i, cout);
         else pass_cnt++;
      end
   endtask

   task automatic test_truth_comb();
      logic [3:0] v;
      reset = 1'b1;
      for (int i = 0; i < 4; i++) begin
         v = vec[i];
         a = v[3];
         b = v[2];
         #1;
         total_cnt++;
         if (sum !== v[0]) $display("FAIL comb_sum a=%b b=%b: got %b want %b", a, b, sum, v[0]);
         else pass_cnt++;
         total_cnt++;
         if (cout !== v[1]) $display("FAIL comb_cout a=%b b=%b: got %b want %b", a, b, cout, v[1]);
         else pass_cnt++;
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_registered();
      logic [3:0] v;
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         v = vec[i];
         a = v[3];
         b = v[2];
         @(posedge clk);
         #1;
         total_cnt++;
         if (sum_q !== v[0]) $display("FAIL reg_sum_q vec %0d: got %b want %b", i, sum_q, v[0]);
         else pass_cnt++;
         total_cnt++;
         if (cout_q !== v[1]) $display("FAIL reg_cout_q vec %0d: got %b want %b", i, cout_q, v[1]);
         else pass_cnt++;
      end
   endtask

   task automatic test_mid_reset();
      reset = 1'b0;
      a     = 1'b0;
      b     = 1'b1;
      @(posedge clk);
      #1;
      total_cnt++;
      if (sum_q !== 1'b1) $display("FAIL mid_pre_sum_q: got %b want 1", sum_q);
      else pass_cnt++;
      reset = 1'b1;
      @(posedge clk);
      #1;
      total_cnt++;
      if (sum_q !== 1'b0) $display("FAIL mid_rst_sum_q: got %b want 0", sum_q);
      else pass_cnt++;
      total_cnt++;
      if (cout_q !== 1'b0) $display("FAIL mid_rst_cout_q: got %b want 0", cout_q);
      else pass_cnt++;
      total_cnt++;
      if (sum !== 1'b1) $display("FAIL mid_rst_sum: got %b want 1", sum);
      else pass_cnt++;
      reset = 1'b0;
      #1;
      total_cnt++;
      if (sum_q !== 1'b0) $display("FAIL mid_deassert_hold_sum_q: got %b want 0", sum_q);
      else pass_cnt++;
      @(posedge clk);
      #1;
      total_cnt++;
      if (sum_q !== 1'b1) $display("FAIL mid_post_sum_q: got %b want 1", sum_q);
      else pass_cnt++;
   endtask

   task automatic test_invariant();
      logic [1:0] exp_now;
      logic [1:0] exp_prev;
      reset    = 1'b0;
      exp_prev = 2'b00;
      for (int i = 0; i < 100; i++) begin
         a = 1'($urandom_range(1, 0));
         b = 1'($urandom_range(1, 0));
         exp_now = {1'b0, a} + {1'b0, b};
         #1;
         total_cnt++;
         if ({cout, sum} !== exp_now)
            $display("FAIL sweep_sum cycle %0d a=%b b=%b: got %b want %b", i, a, b, {cout, sum}, exp_now);
         else pass_cnt++;
         total_cnt++;
         if ((cout & sum) !== 1'b0) $display("FAIL sweep_invariant cycle %0d: cout&sum got %b want 0", i, cout & sum);
         else pass_cnt++;
         if (i > 0) begin
            total_cnt++;
            if ({cout_q, sum_q} !== exp_prev)
               $display("FAIL sweep_reg cycle %0d: got %b want %b", i, {cout_q, sum_q}, exp_prev);
            else pass_cnt++;
         end
         @(posedge clk);
         #1;
         exp_prev = exp_now;
      end
      total_cnt++;
      if ({cout_q, sum_q} !== exp_prev)
         $display("FAIL sweep_reg_last: got %b want %b", {cout_q, sum_q}, exp_prev);
      else pass_cnt++;
   endtask

   initial begin
      pass_cnt  = 0;
      total_cnt = 0;
      reset     = 1'b1;
      a         = 1'b0;
      b         = 1'b0;
      test_reset();
      test_truth_comb();
      test_registered();
      test_mid_reset();
      test_invariant();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/comb_gates_hadd.md
Name: comb_gates_hadd

Overview:
- Single-bit half adder: adds two 1-bit operands and produces a 1-bit sum and a 1-bit carry-out.
- Primary outputs are purely combinational: sum = a XOR b, cout = a AND b.
- Used as a leaf arithmetic cell for ripple and compressor structures.
- Also provides one-cycle registered copies of the results for pipelined consumers.

Parameters:
- None.

Ports:
- clk     input   1  system clock; all registered state updates on the rising edge
- reset   input   1  synchronous, active-high reset
- a       input   1  operand A
- b       input   1  operand B
- sum     output  1  combinational sum bit, a XOR b
- cout    output  1  combinational carry-out, a AND b
- sum_q   output  1  sum registered one cycle after sampling a/b
- cout_q  output  1  cout registered one cycle after sampling a/b

Behaviour:
- Interface: one clock (clk). Reset (reset) is synchronous and active-high.
- Combinational path:
  - sum = a ^ b; cout = a & b.
  - Zero latency, no clock dependence, no storage.
  - Outputs settle within the same evaluation as any change on a or b.
  - Reset has no effect on sum/cout; they track a/b at all times, including while reset is asserted.
- Arithmetic:
  - {cout, sum} is the 2-bit unsigned value of a + b, range 0..2.
  - Invariant: cout and sum are never both 1.
- Registered path:
  - On each rising clk edge with reset=1: sum_q <= 0, cout_q <= 0.
  - On each rising clk edge with reset=0: sum_q <= a ^ b, cout_q <= a & b.
  - Latency is exactly 1 cycle. There is no enable or handshake; the registers capture every cycle.
- Reset and boundary conditions:
  - Reset values: sum_q = 0, cout_q = 0. sum/cout have no reset value because they are combinational.
  - Reset mid-operation: the registered outputs clear on the next edge. The combinational outputs are unaffected.
  - Deassertion: the first edge with reset=0 loads the current a/b result.
- X handling: no X-masking is required. Outputs must be fully determined whenever a and b are known.
- Synthesis: no latches. Combinational logic uses continuous assignments or always_comb with full assignment.

Test Plan:
- Reset: hold reset=1 for 2 cycles with a=1, b=1 -> sum_q=0, cout_q=0; sum=0, cout=1 throughout.
- Truth table, combinational: apply a,b = 0,0 / 0,1 / 1,0 / 1,1, each held one cycle, checked before the next edge:
  - 0,0 -> sum=0, cout=0
  - 0,1 -> sum=1, cout=0
  - 1,0 -> sum=1, cout=0
  - 1,1 -> sum=0, cout=1
- Registered latency: apply the same sequence with reset=0 -> sum_q/cout_q equal the previous cycle's sum/cout. After 1,1 is captured: sum_q=0, cout_q=1.
- Mid-stream reset: with a=0, b=1, assert reset for 1 cycle -> sum_q=0 after that edge, sum stays 1. On the first edge after deassertion, sum_q=1.
- Invariant sweep: random a/b for 100 cycles -> {cout,sum} == a+b every cycle, and cout&sum never 1.
